// File: rtl/adc_capture_buf.sv
// Multi-channel ADC capture engine: decimation, level trigger, pre-trigger ring
// buffer and a one-word-per-cycle synchronous read-out port.
module adc_capture_buf #(
  parameter int unsigned CH_NUM   = 2,
  parameter int unsigned DATA_W   = 14,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned PRE_TRIG = 256,
  parameter int unsigned DEC_W    = 8
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic                       adc_valid,
  input  logic [CH_NUM*DATA_W-1:0]   adc_data,
  input  logic [CH_NUM-1:0]          otr,
  input  logic                       arm,
  input  logic                       abort,
  input  logic [3:0]                 trig_ch,
  input  logic [1:0]                 trig_mode,
  input  logic [DATA_W-1:0]          trig_level,
  input  logic [DEC_W-1:0]           dec_ratio,
  input  logic                       rd_req,
  output logic [CH_NUM*DATA_W-1:0]   rd_data,
  output logic                       rd_valid,
  output logic                       rd_last,
  output logic                       busy,
  output logic                       done,
  output logic [2:0]                 state,
  output logic [CH_NUM-1:0]          otr_seen
);

  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned WORD_W = CH_NUM * DATA_W;
  localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE_TRIG);
  localparam logic [ADDR_W-1:0] POST_INIT = ADDR_W'(DEPTH - PRE_TRIG - 1);
  localparam logic [ADDR_W-1:0] LAST_CNT  = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRE       = 3'd1,
    WAIT_TRIG = 3'd2,
    POST      = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [WORD_W-1:0] mem [DEPTH];

  logic [3:0]        trig_ch_q;
  logic [1:0]        trig_mode_q;
  logic [DATA_W-1:0] trig_level_q;
  logic [DEC_W-1:0]  dec_ratio_q;
  logic [DEC_W-1:0]  dec_cnt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] pre_cnt;
  logic [ADDR_W-1:0] post_cnt;
  logic [ADDR_W-1:0] trig_addr;
  logic [ADDR_W-1:0] rd_cnt;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] prev;
  logic              prev_valid;

  logic              capturing;
  logic              accept;
  logic              arm_go;
  logic              trig_hit;
  logic              rd_issue;
  logic              pre_last;
  logic [DATA_W-1:0] cur_sel;
  logic              rise;
  logic              fall;
  logic              forced;
  logic              trig_cond;

  // Trigger channel select and edge detection against the previous accepted sample
  always_comb begin
    cur_sel = '0;
    for (int unsigned k = 0; k < CH_NUM; k++) begin
      if (32'(trig_ch_q) == k) cur_sel = adc_data[k*DATA_W +: DATA_W];
    end
    rise   = prev_valid && (prev < trig_level_q) && (cur_sel >= trig_level_q);
    fall   = prev_valid && (prev >= trig_level_q) && (cur_sel < trig_level_q);
    forced = (trig_mode_q == 2'b11) || (32'(trig_ch_q) >= CH_NUM);
    case (trig_mode_q)
      2'b00:   trig_cond = rise;
      2'b01:   trig_cond = fall;
      2'b10:   trig_cond = rise || fall;
      default: trig_cond = 1'b1;
    endcase
    trig_cond = trig_cond || forced;
  end

  assign capturing = (state_q == PRE) || (state_q == WAIT_TRIG) || (state_q == POST);
  assign pre_last  = (32'(pre_cnt) + 32'd1) == PRE_TRIG;
  assign rd_addr   = trig_addr - PRE_OFS + rd_cnt;

  // Next state and per-cycle control strobes
  always_comb begin
    state_d  = state_q;
    arm_go   = 1'b0;
    trig_hit = 1'b0;
    rd_issue = 1'b0;
    // a POST entered with zero remaining must not overwrite the window start
    accept   = capturing && adc_valid && (dec_cnt == '0) &&
               !((state_q == POST) && (post_cnt == '0));
    case (state_q)
      IDLE: begin
        if (arm) begin
          arm_go = 1'b1;
          if (PRE_TRIG == 0) state_d = WAIT_TRIG;
          else               state_d = PRE;
        end
      end
      PRE: begin
        if (accept && pre_last) state_d = WAIT_TRIG;
      end
      WAIT_TRIG: begin
        if (accept && trig_cond) begin
          trig_hit = 1'b1;
          state_d  = POST;
        end
      end
      POST: begin
        if (post_cnt == '0)                          state_d = DONE;
        else if (accept && (post_cnt == ADDR_W'(1))) state_d = DONE;
      end
      DONE: begin
        if (arm) begin
          arm_go = 1'b1;
          if (PRE_TRIG == 0) state_d = WAIT_TRIG;
          else               state_d = PRE;
        end else if (rd_req) begin
          rd_issue = 1'b1;
          if (rd_cnt == LAST_CNT) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d  = IDLE;
      arm_go   = 1'b0;
      rd_issue = 1'b0;
      accept   = 1'b0;
      trig_hit = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  assign state = state_q;

  // Sample storage; contents are not reset
  always_ff @(posedge sys_clk) begin
    if (accept) mem[wr_ptr] <= adc_data;
  end

  // Capture datapath, trigger bookkeeping and read-out registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      trig_ch_q    <= '0;
      trig_mode_q  <= '0;
      trig_level_q <= '0;
      dec_ratio_q  <= '0;
      dec_cnt      <= '0;
      wr_ptr       <= '0;
      pre_cnt      <= '0;
      post_cnt     <= '0;
      trig_addr    <= '0;
      rd_cnt       <= '0;
      prev         <= '0;
      prev_valid   <= 1'b0;
      otr_seen     <= '0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
      rd_last      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      busy     <= (state_d == PRE) || (state_d == WAIT_TRIG) || (state_d == POST);
      done     <= (state_d == DONE);
      rd_valid <= rd_issue;
      rd_last  <= rd_issue && (rd_cnt == LAST_CNT);
      if (arm_go) begin
        trig_ch_q    <= trig_ch;
        trig_mode_q  <= trig_mode;
        trig_level_q <= trig_level;
        dec_ratio_q  <= dec_ratio;
        dec_cnt      <= '0;
        wr_ptr       <= '0;
        pre_cnt      <= '0;
        rd_cnt       <= '0;
        prev_valid   <= 1'b0;
        otr_seen     <= '0;
      end else begin
        if (capturing && adc_valid) begin
          dec_cnt <= (dec_cnt == dec_ratio_q) ? '0 : dec_cnt + DEC_W'(1);
        end
        if (accept) begin
          wr_ptr     <= wr_ptr + ADDR_W'(1);
          prev       <= cur_sel;
          prev_valid <= 1'b1;
          otr_seen   <= otr_seen | otr;
          if (state_q == PRE)  pre_cnt  <= pre_cnt + ADDR_W'(1);
          if (state_q == POST) post_cnt <= post_cnt - ADDR_W'(1);
        end
        if (trig_hit) begin
          trig_addr <= wr_ptr;
          post_cnt  <= POST_INIT;
        end
        if (rd_issue) begin
          rd_data <= mem[rd_addr];
          rd_cnt  <= rd_cnt + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_buf.sv
// Scoreboard bench for adc_capture_buf: DEPTH=16, PRE_TRIG=4, two 14-bit channels.
module tb_adc_capture_buf;

  localparam int unsigned CH = 2;
  localparam int unsigned DW = 14;
  localparam int unsigned AW = 4;
  localparam int unsigned PT = 4;
  localparam int unsigned WW = CH * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          adc_valid;
  logic [WW-1:0] adc_data;
  logic [CH-1:0] otr;
  logic          arm;
  logic          abort;
  logic [3:0]    trig_ch;
  logic [1:0]    trig_mode;
  logic [DW-1:0] trig_level;
  logic [7:0]    dec_ratio;
  logic          rd_req;
  logic [WW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_last;
  logic          busy;
  logic          done;
  logic [2:0]    state;
  logic [CH-1:0] otr_seen;

  always #5 clk = ~clk;

  adc_capture_buf #(
    .CH_NUM(CH), .DATA_W(DW), .ADDR_W(AW), .PRE_TRIG(PT), .DEC_W(8)
  ) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .adc_valid(adc_valid), .adc_data(adc_data),
    .otr(otr), .arm(arm), .abort(abort), .trig_ch(trig_ch), .trig_mode(trig_mode),
    .trig_level(trig_level), .dec_ratio(dec_ratio), .rd_req(rd_req),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .busy(busy),
    .done(done), .state(state), .otr_seen(otr_seen)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [WW:0] exp_q[$];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic sample(input int c0, input int c1, input logic [1:0] o);
    adc_valid = 1'b1;
    adc_data  = {DW'(c1), DW'(c0)};
    otr       = o;
    cyc();
    adc_valid = 1'b0;
    otr       = '0;
    cyc();
    cyc();
  endtask

  task automatic do_arm(input int ch, input int mode, input int lvl, input int dec);
    trig_ch    = 4'(ch);
    trig_mode  = 2'(mode);
    trig_level = DW'(lvl);
    dec_ratio  = 8'(dec);
    arm = 1'b1;
    cyc();
    arm = 1'b0;
  endtask

  task automatic push_exp(input int c0, input int c1, input bit last);
    exp_q.push_back({last, DW'(c1), DW'(c0)});
  endtask

  task automatic read_n(input int n);
    rd_req = 1'b1;
    cyc();
    chk("rd_latency", rd_valid, 1);
    repeat (n - 1) cyc();
    rd_req = 1'b0;
    cyc();
    cyc();
  endtask

  // Pops one expected word per rd_valid and flags any word nobody asked for
  task automatic monitor();
    logic [WW:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && rd_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_rd_valid: actual rd_valid=1 (data=%0h) required=0", rd_data);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", 64'(rd_data), 64'(e[WW-1:0]));
          chk("rd_last", 64'(rd_last), 64'(e[WW]));
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; adc_valid = 1'b0; adc_data = '0; otr = '0; arm = 1'b0; abort = 1'b0;
    trig_ch = '0; trig_mode = '0; trig_level = '0; dec_ratio = '0; rd_req = 1'b0;
    fork
      monitor();
      begin
        repeat (3) cyc();
        chk("reset_state", state, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_rd_valid", rd_valid, 0);
        chk("reset_otr_seen", otr_seen, 0);
        rst_n = 1'b1;
        cyc();

        // rising ramp on ch0, trigger at 100
        do_arm(0, 0, 100, 0);
        chk("ramp_arm_state", state, 1);
        for (int v = 90; v <= 93; v++) sample(v, 1000 + v, 2'b00);
        chk("ramp_wait_state", state, 2);
        for (int v = 94; v <= 111; v++) sample(v, 1000 + v, 2'b00);
        chk("ramp_done", done, 1);
        chk("ramp_state_done", state, 4);
        chk("ramp_busy", busy, 0);
        for (int i = 0; i < 16; i++) push_exp(96 + i, 1096 + i, i == 15);
        read_n(16);
        chk("ramp_idle_after", state, 0);
        chk("ramp_done_fell", done, 0);

        // falling ramp on ch1, trigger at 149
        do_arm(1, 1, 150, 0);
        for (int v = 200; v >= 138; v--) sample(7, v, 2'b00);
        chk("fall_done", done, 1);
        for (int i = 0; i < 16; i++) push_exp(7, 153 - i, i == 15);
        read_n(16);

        // decimate by 3, immediate trigger
        do_arm(0, 3, 0, 2);
        for (int v = 0; v <= 45; v++) sample(v, 0, 2'b00);
        chk("dec_done", done, 1);
        for (int i = 0; i < 16; i++) push_exp(3 * i, 0, i == 15);
        read_n(16);

        // trig_ch out of range forces trigger; one otr sample on ch1
        do_arm(7, 0, 0, 0);
        for (int i = 0; i < 15; i++) sample(500, 0, (i == 2) ? 2'b10 : 2'b00);
        chk("forced_busy_15", busy, 1);
        sample(500, 0, 2'b00);
        chk("forced_busy_16", busy, 0);
        chk("forced_done", done, 1);
        chk("otr_seen_done", otr_seen, 2);
        sample(999, 0, 2'b01);
        chk("otr_seen_ignored", otr_seen, 2);
        for (int i = 0; i < 16; i++) push_exp(500, 0, i == 15);
        read_n(16);
        chk("otr_seen_after_read", otr_seen, 2);

        // abort during POST, then arm+abort together
        do_arm(0, 3, 0, 0);
        chk("otr_seen_cleared", otr_seen, 0);
        for (int i = 0; i < 8; i++) sample(20 + i, 0, 2'b00);
        chk("abort_pre_state", state, 3);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort_state", state, 0);
        chk("abort_busy", busy, 0);
        rd_req = 1'b1;
        repeat (4) cyc();
        rd_req = 1'b0;
        cyc();
        arm = 1'b1;
        abort = 1'b1;
        cyc();
        arm = 1'b0;
        abort = 1'b0;
        chk("arm_abort_state", state, 0);
        chk("arm_abort_busy", busy, 0);

        // asynchronous reset while waiting for a trigger
        do_arm(0, 0, 10000, 0);
        for (int i = 0; i < 6; i++) sample(30 + i, 0, (i == 1) ? 2'b11 : 2'b00);
        chk("rst_pre_state", state, 2);
        chk("rst_pre_otr", otr_seen, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_state", state, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_otr", otr_seen, 0);
        chk("async_rst_rd_valid", rd_valid, 0);
        chk("async_rst_rd_last", rd_last, 0);
        chk("async_rst_rd_data", 64'(rd_data), 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("exp_queue_empty", exp_q.size(), 0);
      end
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
